// File: rtl/aes_pkg.sv
// Shared AES controller types and constants.
// Block width, round-index width, key-size round counts, FSM encoding.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_ROUND_W = 4;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_ROUND_W-1:0] aes_round_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-level plaintext/ciphertext valid-ready streams.
// master drives plaintext and consumes ciphertext; slave is the controller.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_block_t in_block;
  logic       out_valid;
  logic       out_ready;
  aes_block_t out_block;

  modport master (
    output in_valid,
    output in_block,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_block
  );

  modport slave (
    input  in_valid,
    input  in_block,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_block
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES sequencer: owns state register and round counter,
// steps an external round datapath once per round.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = NR_128,
  parameter int DP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  aes_round_ctrl_if.slave  bus,
  output aes_block_t       dp_state_o,
  output aes_round_t       dp_round_o,
  output logic             dp_last_o,
  input  aes_block_t       dp_result_i,
  output aes_round_t       rk_round_o,
  input  aes_block_t       rk_in_i,
  output logic             busy_o
);

  localparam aes_round_t LAST = AES_ROUND_W'(NR);
  localparam logic [1:0] LAT  = 2'(DP_LAT);

  ctrl_state_t state_q, state_d;
  aes_round_t  round_q, round_d;
  logic [1:0]  wait_q, wait_d;
  aes_block_t  data_q, data_d;
  logic        step;

  // datapath output has settled for the current round
  assign step = (wait_q == LAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wait_d  = wait_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_block ^ rk_in_i;
          round_d = AES_ROUND_W'(1);
          wait_d  = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (!step) begin
          wait_d = wait_q + 2'd1;
        end else begin
          data_d = dp_result_i;
          wait_d = '0;
          if (round_q == LAST) begin
            state_d = DONE;
          end else begin
            round_d = round_q + AES_ROUND_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      round_d = '0;
      wait_d  = '0;
      data_d  = '0;
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_block = '0;
    dp_round_o    = '0;
    dp_last_o     = 1'b0;
    busy_o        = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy_o       = 1'b0;
      end
      ROUND: begin
        dp_round_o = round_q;
        dp_last_o  = (round_q == LAST);
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_block = data_q;
      end
      default: ;
    endcase
  end

  assign dp_state_o = data_q;
  assign rk_round_o = dp_round_o;

  a_cfg: assert property (@(posedge clk)
    (NR == NR_128 || NR == NR_192 || NR == NR_256)
    && DP_LAT >= 0 && DP_LAT <= 3);

  a_round_max: assert property (@(posedge clk)
    round_q <= LAST);

  a_excl: assert property (@(posedge clk)
    !(bus.out_valid && bus.in_ready));

  a_hold: assert property (@(posedge clk)
    disable iff (rst || clear_i)
    (bus.out_valid && !bus.out_ready)
    |=> $stable(bus.out_block));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES round
// datapath and key schedule (FIPS-197 C.1), plus a stub datapath.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam aes_block_t KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t PT  = 128'h00112233445566778899aabbccddeeff;
  localparam aes_block_t CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clear0, clear1;
  logic stub_mode;
  int   compared;
  int   mismatched;

  logic [7:0] sbox [256];
  aes_block_t rkey [11];

  aes_round_ctrl_if u_if0 ();
  aes_round_ctrl_if u_if1 ();

  aes_block_t dp_state0, dp_result0, rk_in0;
  aes_block_t dp_state1, dp_result1, rk_in1;
  aes_round_t dp_round0, rk_round0;
  aes_round_t dp_round1, rk_round1;
  logic       dp_last0, busy0, dp_last1, busy1;
  aes_block_t p1_q, p2_q;

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic aes_block_t aes_round(aes_block_t s, aes_round_t r,
                                           logic last);
    logic [7:0] b  [16];
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    aes_block_t o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int q = 0; q < 4; q++)
        sr[4*c+q] = b[4*((c+q)%4)+q];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[4*c];   a1 = sr[4*c+1];
        a2 = sr[4*c+2]; a3 = sr[4*c+3];
        sr[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        sr[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        sr[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        sr[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sr[i];
    return o ^ ((r <= 4'd10) ? rkey[r] : '0);
  endfunction

  assign dp_result0 = stub_mode ? (dp_state0 + 128'(dp_round0))
                                : aes_round(dp_state0, dp_round0, dp_last0);
  assign rk_in0 = stub_mode ? '0
                : ((rk_round0 <= 4'd10) ? rkey[rk_round0] : '0);

  // two-stage pipe models a DP_LAT=2 datapath
  always @(posedge clk) begin
    p1_q <= aes_round(dp_state1, dp_round1, dp_last1);
    p2_q <= p1_q;
  end
  assign dp_result1 = p2_q;
  assign rk_in1 = (rk_round1 <= 4'd10) ? rkey[rk_round1] : '0;

  aes_round_ctrl #(.NR(10), .DP_LAT(0)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear0),
    .bus         (u_if0),
    .dp_state_o  (dp_state0),
    .dp_round_o  (dp_round0),
    .dp_last_o   (dp_last0),
    .dp_result_i (dp_result0),
    .rk_round_o  (rk_round0),
    .rk_in_i     (rk_in0),
    .busy_o      (busy0)
  );

  aes_round_ctrl #(.NR(10), .DP_LAT(2)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear1),
    .bus         (u_if1),
    .dp_state_o  (dp_state1),
    .dp_round_o  (dp_round1),
    .dp_last_o   (dp_last1),
    .dp_result_i (dp_result1),
    .rk_round_o  (rk_round1),
    .rk_in_i     (rk_in1),
    .busy_o      (busy1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic build_tables();
    logic [7:0]  inv;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
              ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rkey[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // offer blk on instance 0, then count edges until out_valid
  task automatic send0(input aes_block_t blk, output int lat);
    u_if0.in_valid = 1'b1;
    u_if0.in_block = blk;
    tick();
    u_if0.in_valid = 1'b0;
    u_if0.in_block = '0;
    lat = 0;
    while (u_if0.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    compared++;
    if (u_if0.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_in_ready: got %b want 1", u_if0.in_ready);
    end
    compared++;
    if (u_if0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_valid_busy: got %b%b want 00",
               u_if0.out_valid, busy0);
    end
    compared++;
    if (dp_last0 !== 1'b0 || dp_round0 !== 4'd0) begin
      mismatched++;
      $display("FAIL rst_dp: got last=%b round=%0d want 0/0",
               dp_last0, dp_round0);
    end
    compared++;
    if (u_if0.out_block !== '0 || dp_state0 !== '0) begin
      mismatched++;
      $display("FAIL rst_block: got %h/%h want 0",
               u_if0.out_block, dp_state0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips();
    int lat;
    send0(PT, lat);
    compared++;
    if (lat !== 10) begin
      mismatched++;
      $display("FAIL fips_latency: got %0d want 10", lat);
    end
    compared++;
    if (u_if0.out_block !== CT) begin
      mismatched++;
      $display("FAIL fips_ct: got %h want %h", u_if0.out_block, CT);
    end
    compared++;
    if (busy0 !== 1'b1 || u_if0.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL fips_done_flags: got busy=%b rdy=%b want 1/0",
               busy0, u_if0.in_ready);
    end
    u_if0.out_ready = 1'b1;
    tick();
    u_if0.out_ready = 1'b0;
    compared++;
    if (u_if0.out_valid !== 1'b0 || u_if0.in_ready !== 1'b1
        || busy0 !== 1'b0 || u_if0.out_block !== '0) begin
      mismatched++;
      $display("FAIL fips_after_hs: got v=%b r=%b b=%b blk=%h want 0/1/0/0",
               u_if0.out_valid, u_if0.in_ready, busy0, u_if0.out_block);
    end
  endtask

  task automatic test_stub();
    stub_mode = 1'b1;
    u_if0.in_valid = 1'b1;
    u_if0.in_block = '0;
    tick();
    u_if0.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      compared++;
      if (dp_round0 !== 4'(k) || rk_round0 !== 4'(k)
          || dp_last0 !== (k == 10) || u_if0.out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL stub_round%0d: got rnd=%0d rk=%0d last=%b v=%b want %0d/%0d/%b/0",
                 k, dp_round0, rk_round0, dp_last0, u_if0.out_valid,
                 k, k, (k == 10));
      end
      tick();
    end
    compared++;
    if (u_if0.out_valid !== 1'b1 || u_if0.out_block !== 128'h37) begin
      mismatched++;
      $display("FAIL stub_sum: got v=%b blk=%h want 1/37",
               u_if0.out_valid, u_if0.out_block);
    end
    compared++;
    if (dp_last0 !== 1'b0 || dp_round0 !== 4'd0) begin
      mismatched++;
      $display("FAIL stub_done_dp: got last=%b rnd=%0d want 0/0",
               dp_last0, dp_round0);
    end
    u_if0.out_ready = 1'b1;
    tick();
    u_if0.out_ready = 1'b0;
    stub_mode = 1'b0;
  endtask

  task automatic test_latency();
    u_if1.in_valid = 1'b1;
    u_if1.in_block = PT;
    tick();
    u_if1.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      for (int j = 0; j < 3; j++) begin
        compared++;
        if (dp_round1 !== 4'(k) || u_if1.out_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL lat2_round%0d_%0d: got rnd=%0d v=%b want %0d/0",
                   k, j, dp_round1, u_if1.out_valid, k);
        end
        tick();
      end
    end
    compared++;
    if (u_if1.out_valid !== 1'b1 || u_if1.out_block !== CT) begin
      mismatched++;
      $display("FAIL lat2_ct: got v=%b blk=%h want 1/%h",
               u_if1.out_valid, u_if1.out_block, CT);
    end
    u_if1.out_ready = 1'b1;
    tick();
    u_if1.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    u_if0.in_valid = 1'b1;
    u_if0.in_block = PT;
    tick();
    lat = 0;
    while (u_if0.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    compared++;
    if (lat !== 10) begin
      mismatched++;
      $display("FAIL bp_latency: got %0d want 10", lat);
    end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (u_if0.out_block !== CT || u_if0.in_ready !== 1'b0
          || u_if0.out_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got blk=%h r=%b v=%b want %h/0/1",
                 i, u_if0.out_block, u_if0.in_ready, u_if0.out_valid, CT);
      end
      tick();
    end
    u_if0.out_ready = 1'b1;
    tick();
    compared++;
    if (busy0 !== 1'b0 || u_if0.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_idle_gap: got busy=%b r=%b want 0/1",
               busy0, u_if0.in_ready);
    end
    tick();
    compared++;
    if (busy0 !== 1'b1 || u_if0.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_second_accept: got busy=%b r=%b want 1/0",
               busy0, u_if0.in_ready);
    end
    u_if0.in_valid = 1'b0;
    lat = 0;
    while (u_if0.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    compared++;
    if (lat !== 10 || u_if0.out_block !== CT) begin
      mismatched++;
      $display("FAIL bp_second_ct: got lat=%0d blk=%h want 10/%h",
               lat, u_if0.out_block, CT);
    end
    tick();
    u_if0.out_ready = 1'b0;
  endtask

  task automatic test_clear();
    int lat;
    int seen;
    u_if0.in_valid = 1'b1;
    u_if0.in_block = PT;
    tick();
    u_if0.in_valid = 1'b0;
    tick();
    tick();
    tick();
    compared++;
    if (dp_round0 !== 4'd4) begin
      mismatched++;
      $display("FAIL clr_at_round: got %0d want 4", dp_round0);
    end
    clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    compared++;
    if (busy0 !== 1'b0 || u_if0.in_ready !== 1'b1
        || u_if0.out_valid !== 1'b0 || dp_state0 !== '0) begin
      mismatched++;
      $display("FAIL clr_flush: got busy=%b r=%b v=%b st=%h want 0/1/0/0",
               busy0, u_if0.in_ready, u_if0.out_valid, dp_state0);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (u_if0.out_valid === 1'b1) seen++;
      tick();
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL clr_no_output: got %0d valid cycles want 0", seen);
    end
    clear0 = 1'b1;
    u_if0.in_valid = 1'b1;
    tick();
    clear0 = 1'b0;
    u_if0.in_valid = 1'b0;
    compared++;
    if (busy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL clr_vs_accept: got busy=%b want 0", busy0);
    end
    send0(PT, lat);
    compared++;
    if (lat !== 10 || u_if0.out_block !== CT) begin
      mismatched++;
      $display("FAIL clr_next_block: got lat=%0d blk=%h want 10/%h",
               lat, u_if0.out_block, CT);
    end
  endtask

  task automatic test_rst_done();
    compared++;
    if (u_if0.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rstd_pre: got v=%b want 1", u_if0.out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (u_if0.out_valid !== 1'b0 || u_if0.out_block !== '0
        || u_if0.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rstd_flush: got v=%b blk=%h r=%b want 0/0/1",
               u_if0.out_valid, u_if0.out_block, u_if0.in_ready);
    end
    rst = 1'b1;
    u_if0.in_valid = 1'b1;
    u_if0.in_block = PT;
    tick();
    rst = 1'b0;
    u_if0.in_valid = 1'b0;
    tick();
    compared++;
    if (busy0 !== 1'b0 || u_if0.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_vs_accept: got busy=%b r=%b want 0/1",
               busy0, u_if0.in_ready);
    end
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    rst             = 1'b1;
    clear0          = 1'b0;
    clear1          = 1'b0;
    stub_mode       = 1'b0;
    u_if0.in_valid  = 1'b0;
    u_if0.in_block  = '0;
    u_if0.out_ready = 1'b0;
    u_if1.in_valid  = 1'b0;
    u_if1.in_block  = '0;
    u_if1.out_ready = 1'b0;
    build_tables();
    @(negedge clk);
    test_reset();
    test_fips();
    test_stub();
    test_latency();
    test_back_to_back();
    test_clear();
    test_rst_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
